// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   SPI mode-0 master (CPOL=0, CPHA=0), MSB first, full duplex.
//   Bytes arrive over a valid/ready stream and are shifted out on MOSI. At the
//   same time a byte is shifted in from MISO and returned with a one-cycle
//   rx_valid pulse. A burst keeps cs_n low until the byte tagged tx_last has
//   been shifted. All outputs are registered.
//
// Ports
//   clk       in   1       system clock, rising edge
//   rst       in   1       asynchronous active-high reset
//   tx_data   in   DATA_W  byte to transmit, sampled on accept
//   tx_valid  in   1       tx_data/tx_last valid
//   tx_last   in   1       byte ends the frame
//   tx_ready  out  1       master accepts a byte this cycle
//   rx_data   out  DATA_W  last byte received, held until the next one
//   rx_valid  out  1       one-cycle pulse, rx_data updated
//   busy      out  1       state is not IDLE
//   sclk      out  1       SPI clock, idles low
//   cs_n      out  1       chip select, active low
//   mosi      out  1       serial data out
//   miso      in   1       serial data in
// -----------------------------------------------------------------------------
module spi_master #(
   parameter int DATA_W   = 8,
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_IDLE  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   input  logic              tx_last,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              sclk,
   output logic              cs_n,
   output logic              mosi,
   input  logic              miso
);

   // One shared down-counter serves the SCLK half-period, the CS setup/hold
   // and the inter-frame gap, so it is sized for the largest of the three.
   localparam int CNT_M1  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int CNT_MAX = (CNT_M1 > CS_IDLE) ? CNT_M1 : CS_IDLE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
   localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_NEXT  = 3'd3,
      ST_HOLD  = 3'd4,
      ST_GAP   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic                samp_q, samp_d;
   logic                last_q, last_d;
   logic                tx_ready_q, tx_ready_d;
   logic [DATA_W-1:0]   rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                busy_q, busy_d;
   logic                sclk_q, sclk_d;
   logic                cs_n_q, cs_n_d;
   logic                mosi_q, mosi_d;
   logic                accept;

   assign accept   = tx_valid && tx_ready_q;

   assign tx_ready = tx_ready_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = busy_q;
   assign sclk     = sclk_q;
   assign cs_n     = cs_n_q;
   assign mosi     = mosi_q;

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      samp_d     = samp_q;
      last_d     = last_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      sclk_d     = sclk_q;
      cs_n_d     = cs_n_q;
      mosi_d     = mosi_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               shreg_d = tx_data;
               last_d  = tx_last;
               mosi_d  = tx_data[DATA_W-1];
               cs_n_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_SETUP;
            end else begin
               cs_n_d  = 1'b1;
               sclk_d  = 1'b0;
            end
         end

         ST_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = ST_SHIFT;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end

         ST_SHIFT: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d = '0;
               if (!sclk_q) begin
                  // Rising edge: capture MISO; it enters the shift LSB at the fall.
                  sclk_d = 1'b1;
                  samp_d = miso;
               end else begin
                  // Falling edge: shift and present the next MOSI bit.
                  sclk_d  = 1'b0;
                  shreg_d = {shreg_q[DATA_W-2:0], samp_q};
                  mosi_d  = shreg_q[DATA_W-2];
                  if (bit_q == BIT_LAST) begin
                     rx_data_d  = {shreg_q[DATA_W-2:0], samp_q};
                     rx_valid_d = 1'b1;
                     mosi_d     = 1'b0;
                     state_d    = last_q ? ST_HOLD : ST_NEXT;
                  end else begin
                     bit_d = bit_q + BIT_ONE;
                  end
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         ST_NEXT: begin
            // cs_n stays low and sclk idles until upstream offers the next byte.
            if (accept) begin
               shreg_d = tx_data;
               last_d  = tx_last;
               mosi_d  = tx_data[DATA_W-1];
               cnt_d   = '0;
               bit_d   = '0;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_NEXT;
            end
         end

         ST_HOLD: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = '0;
               cs_n_d  = 1'b1;
               state_d = ST_GAP;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end

         ST_GAP: begin
            if (cnt_q == IDLE_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sclk_d  = 1'b0;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
         end
      endcase

      // Registered handshake/status follow the state being entered.
      tx_ready_d = (state_d == ST_IDLE) || (state_d == ST_NEXT);
      busy_d     = (state_d != ST_IDLE);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         samp_q     <= 1'b0;
         last_q     <= 1'b0;
         tx_ready_q <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         sclk_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
         samp_q     <= samp_d;
         last_q     <= last_d;
         tx_ready_q <= tx_ready_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         busy_q     <= busy_d;
         sclk_q     <= sclk_d;
         cs_n_q     <= cs_n_d;
         mosi_q     <= mosi_d;
      end
   end

endmodule
